// File: rtl/hazard_control_unit_if.sv
// Hazard-unit bundle: pipeline hazard sources in, stall/flush controls out.
interface hazard_control_unit_if;
  logic       ID_EX_MemRead;
  logic       ID_EX_RegWrite;
  logic [4:0] ID_EX_Rd;
  logic       EX_MEM_MemRead;
  logic [4:0] EX_MEM_Rd;
  logic [4:0] IF_ID_Rs;
  logic [4:0] IF_ID_Rt;
  logic       IF_ID_UseRt;
  logic       ID_Branch;
  logic       ID_BranchTaken;
  logic       ID_MdStart;
  logic       ID_MfHiLo;
  logic       PCWrite;
  logic       IF_ID_Write;
  logic       ID_EX_Bubble;
  logic       IF_ID_Flush;
  logic       MdBusy;
  logic [31:0] StallCount;

  // pipeline side
  modport master (
    output ID_EX_MemRead, ID_EX_RegWrite, ID_EX_Rd, EX_MEM_MemRead, EX_MEM_Rd,
           IF_ID_Rs, IF_ID_Rt, IF_ID_UseRt, ID_Branch, ID_BranchTaken,
           ID_MdStart, ID_MfHiLo,
    input  PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, MdBusy, StallCount
  );

  // hazard unit side
  modport slave (
    input  ID_EX_MemRead, ID_EX_RegWrite, ID_EX_Rd, EX_MEM_MemRead, EX_MEM_Rd,
           IF_ID_Rs, IF_ID_Rt, IF_ID_UseRt, ID_Branch, ID_BranchTaken,
           ID_MdStart, ID_MfHiLo,
    output PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, MdBusy, StallCount
  );
endinterface

// File: rtl/hazard_control_unit.sv
// Load-use / ID-branch / mult-div stall and flush controller for the 5-stage pipe.
// Optional stall-cycle counter enabled by `define HAZARD_STALL_COUNTER_EN.
module hazard_control_unit #(
  parameter int MD_LATENCY = 32,
  parameter int CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  hazard_control_unit_if.slave hif
);
  typedef enum logic {RUN, MD_BUSY} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             ex_match, mem_match;
  logic             load_use, br_haz, md_haz, stall;

  assign ex_match  = (hif.ID_EX_Rd != 5'd0) &&
                     ((hif.ID_EX_Rd == hif.IF_ID_Rs) ||
                      (hif.IF_ID_UseRt && (hif.ID_EX_Rd == hif.IF_ID_Rt)));
  assign mem_match = (hif.EX_MEM_Rd != 5'd0) &&
                     ((hif.EX_MEM_Rd == hif.IF_ID_Rs) ||
                      (hif.IF_ID_UseRt && (hif.EX_MEM_Rd == hif.IF_ID_Rt)));

  assign load_use = hif.ID_EX_MemRead && ex_match;
  // ID-stage compare needs the value itself, so ALU results in EX and loads in MEM both block it
  assign br_haz   = hif.ID_Branch &&
                    ((hif.ID_EX_RegWrite && ex_match) || (hif.EX_MEM_MemRead && mem_match));
  assign md_haz   = (state == MD_BUSY) && (hif.ID_MfHiLo || hif.ID_MdStart);
  assign stall    = load_use || br_haz || md_haz;

  assign hif.MdBusy = (state == MD_BUSY);

  always_comb begin
    hif.PCWrite      = 1'b1;
    hif.IF_ID_Write  = 1'b1;
    hif.ID_EX_Bubble = 1'b0;
    hif.IF_ID_Flush  = hif.ID_Branch && hif.ID_BranchTaken;
    if (rst) begin
      hif.PCWrite      = 1'b0;
      hif.IF_ID_Write  = 1'b0;
      hif.ID_EX_Bubble = 1'b1;
      hif.IF_ID_Flush  = 1'b1;
    end else if (stall) begin
      // a stalled branch is re-resolved next cycle, so never flush on it now
      hif.PCWrite      = 1'b0;
      hif.IF_ID_Write  = 1'b0;
      hif.ID_EX_Bubble = 1'b1;
      hif.IF_ID_Flush  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      case (state)
        RUN: if (hif.ID_MdStart && !stall) begin
          state <= MD_BUSY;
          cnt   <= CNT_W'(MD_LATENCY);
        end
        MD_BUSY: if (cnt == CNT_W'(1)) begin
          state <= RUN;
          cnt   <= '0;
        end else begin
          cnt <= cnt - CNT_W'(1);
        end
        default: begin
          state <= RUN;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef HAZARD_STALL_COUNTER_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (rst)                                stall_cnt <= '0;
    else if (stall && (stall_cnt != '1))    stall_cnt <= stall_cnt + 32'd1;
  end

  assign hif.StallCount = stall_cnt;
`else
  assign hif.StallCount = '0;
`endif
endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: cycle-indexed reference model plus directed literal checks.
module tb_hazard_control_unit;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_control_unit_if hif ();
  hazard_control_unit_if hif1 ();

  hazard_control_unit #(.MD_LATENCY(LAT), .CNT_W(8)) dut (.clk(clk), .rst(rst), .hif(hif));
  hazard_control_unit #(.MD_LATENCY(1),   .CNT_W(8)) dut1 (.clk(clk), .rst(rst), .hif(hif1));

  assign hif1.ID_EX_MemRead  = hif.ID_EX_MemRead;
  assign hif1.ID_EX_RegWrite = hif.ID_EX_RegWrite;
  assign hif1.ID_EX_Rd       = hif.ID_EX_Rd;
  assign hif1.EX_MEM_MemRead = hif.EX_MEM_MemRead;
  assign hif1.EX_MEM_Rd      = hif.EX_MEM_Rd;
  assign hif1.IF_ID_Rs       = hif.IF_ID_Rs;
  assign hif1.IF_ID_Rt       = hif.IF_ID_Rt;
  assign hif1.IF_ID_UseRt    = hif.IF_ID_UseRt;
  assign hif1.ID_Branch      = hif.ID_Branch;
  assign hif1.ID_BranchTaken = hif.ID_BranchTaken;
  assign hif1.ID_MdStart     = hif.ID_MdStart;
  assign hif1.ID_MfHiLo      = hif.ID_MfHiLo;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  // Model: unit is busy in the LAT cycles following the cycle a mult/div was accepted.
  int cyc = 0;
  int accept_cyc = -100;
  int exp_stalls = 0;

  function automatic bit m_match(input logic [4:0] r);
    return (r != 0) && ((r == hif.IF_ID_Rs) || (hif.IF_ID_UseRt && (r == hif.IF_ID_Rt)));
  endfunction

  function automatic bit m_busy();
    return (cyc > accept_cyc) && (cyc <= accept_cyc + LAT);
  endfunction

  function automatic bit m_stall();
    bit lu, br, md;
    lu = hif.ID_EX_MemRead && m_match(hif.ID_EX_Rd);
    br = hif.ID_Branch && ((hif.ID_EX_RegWrite && m_match(hif.ID_EX_Rd)) ||
                           (hif.EX_MEM_MemRead && m_match(hif.EX_MEM_Rd)));
    md = m_busy() && (hif.ID_MfHiLo || hif.ID_MdStart);
    return lu || br || md;
  endfunction

  function automatic logic [31:0] exp_sc();
`ifdef HAZARD_STALL_COUNTER_EN
    return exp_stalls;
`else
    return 32'd0;
`endif
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      accept_cyc <= -100;
      exp_stalls <= 0;
    end else begin
      if (m_stall()) exp_stalls <= exp_stalls + 1;
      if (hif.ID_MdStart && !m_busy() && !m_stall()) accept_cyc <= cyc;
    end
    cyc <= cyc + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      bit st;
      st = m_stall();
      chk("cmp_pcwrite", hif.PCWrite,      rst ? 1'b0 : !st);
      chk("cmp_ifidwr",  hif.IF_ID_Write,  rst ? 1'b0 : !st);
      chk("cmp_bubble",  hif.ID_EX_Bubble, rst ? 1'b1 : st);
      chk("cmp_flush",   hif.IF_ID_Flush,  rst ? 1'b1 : (!st && hif.ID_Branch && hif.ID_BranchTaken));
      chk("cmp_mdbusy",  hif.MdBusy,       m_busy());
      chk("cmp_stallcnt", hif.StallCount,  exp_sc());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    hif.ID_EX_MemRead = 0; hif.ID_EX_RegWrite = 0; hif.ID_EX_Rd = 0;
    hif.EX_MEM_MemRead = 0; hif.EX_MEM_Rd = 0;
    hif.IF_ID_Rs = 0; hif.IF_ID_Rt = 0; hif.IF_ID_UseRt = 0;
    hif.ID_Branch = 0; hif.ID_BranchTaken = 0; hif.ID_MdStart = 0; hif.ID_MfHiLo = 0;
  endtask

  initial begin
    clr();
    rst = 1;
    tick();
    cmp_en = 1;
    @(negedge clk);
    chk("rst_pcwrite", hif.PCWrite, 0);
    chk("rst_ifidwr",  hif.IF_ID_Write, 0);
    chk("rst_bubble",  hif.ID_EX_Bubble, 1);
    chk("rst_flush",   hif.IF_ID_Flush, 1);
    chk("rst_mdbusy",  hif.MdBusy, 0);
    chk("rst_stallcnt", hif.StallCount, 0);
    tick();
    rst = 0;

    // idle
    @(negedge clk); chk("idle_pcwrite", hif.PCWrite, 1); tick();
    // load-use on rs
    hif.ID_EX_MemRead = 1; hif.ID_EX_Rd = 8; hif.IF_ID_Rs = 8;
    @(negedge clk);
    chk("lu_pcwrite", hif.PCWrite, 0);
    chk("lu_ifidwr",  hif.IF_ID_Write, 0);
    chk("lu_bubble",  hif.ID_EX_Bubble, 1);
    tick();
    // r0 never hazards
    hif.ID_EX_Rd = 0; hif.IF_ID_Rs = 0;
    @(negedge clk); chk("lu_r0_pcwrite", hif.PCWrite, 1); tick();
    // rt only counts when read
    hif.ID_EX_Rd = 9; hif.IF_ID_Rt = 9; hif.IF_ID_Rs = 3; hif.IF_ID_UseRt = 0;
    @(negedge clk); chk("rt_unused_pcwrite", hif.PCWrite, 1); tick();
    hif.IF_ID_UseRt = 1;
    @(negedge clk); chk("rt_used_pcwrite", hif.PCWrite, 0); tick();
    clr();

    // branch waits on load in MEM, then flushes
    hif.ID_Branch = 1; hif.ID_BranchTaken = 1; hif.EX_MEM_MemRead = 1;
    hif.EX_MEM_Rd = 5; hif.IF_ID_Rs = 5;
    @(negedge clk);
    chk("br_stall_pcwrite", hif.PCWrite, 0);
    chk("br_stall_flush",   hif.IF_ID_Flush, 0);
    tick();
    hif.EX_MEM_MemRead = 0;
    @(negedge clk);
    chk("br_go_flush",   hif.IF_ID_Flush, 1);
    chk("br_go_pcwrite", hif.PCWrite, 1);
    tick();
    hif.ID_EX_RegWrite = 1; hif.ID_EX_Rd = 7; hif.IF_ID_Rs = 7;
    @(negedge clk);
    chk("br_ex_pcwrite", hif.PCWrite, 0);
    chk("br_ex_flush",   hif.IF_ID_Flush, 0);
    tick();
    clr();

    // mult/div at t, mfhi at t+2
    hif.ID_MdStart = 1;
    @(negedge clk); chk("md_t_busy", hif.MdBusy, 0); chk("md_t_pcwrite", hif.PCWrite, 1); tick();
    hif.ID_MdStart = 0;
    @(negedge clk); chk("md_t1_busy", hif.MdBusy, 1); chk("lat1_t1_busy", hif1.MdBusy, 1); tick();
    hif.ID_MfHiLo = 1;
    @(negedge clk);
    chk("md_t2_pcwrite", hif.PCWrite, 0);
    chk("md_t2_busy", hif.MdBusy, 1);
    chk("lat1_t2_busy", hif1.MdBusy, 0);
    tick();
    tick();
    @(negedge clk); chk("md_t4_pcwrite", hif.PCWrite, 0); tick();
    @(negedge clk);
    chk("md_t5_busy", hif.MdBusy, 0);
    chk("md_t5_pcwrite", hif.PCWrite, 1);
`ifdef HAZARD_STALL_COUNTER_EN
    chk("stallcnt_lit", hif.StallCount, 7);
`else
    chk("stallcnt_lit", hif.StallCount, 0);
`endif
    tick();
    clr();

    // back-to-back mult/div: second one waits out the first
    hif.ID_MdStart = 1;
    @(negedge clk); chk("b2b_t_busy", hif.MdBusy, 0); tick();
    @(negedge clk); chk("b2b_t1_pcwrite", hif.PCWrite, 0); tick();
    repeat (3) tick();
    @(negedge clk); chk("b2b_t5_busy", hif.MdBusy, 0); chk("b2b_t5_pcwrite", hif.PCWrite, 1); tick();
    hif.ID_MdStart = 0;
    @(negedge clk); chk("b2b_t6_busy", hif.MdBusy, 1); tick();
    repeat (6) tick();

    // reset while busy
    hif.ID_MdStart = 1; tick();
    hif.ID_MdStart = 0; tick();
    rst = 1;
    @(negedge clk);
    chk("rstmid_pcwrite", hif.PCWrite, 0);
    chk("rstmid_flush",   hif.IF_ID_Flush, 1);
    chk("rstmid_busy",    hif.MdBusy, 1);
    tick();
    @(negedge clk);
    chk("rstmid_busy_after", hif.MdBusy, 0);
    chk("rstmid_stallcnt",   hif.StallCount, 0);
    tick();
    rst = 0;

    // mixed vectors over a small register range so matches are frequent
    for (int i = 0; i < 300; i++) begin
      hif.ID_EX_MemRead  = $urandom_range(1, 0);
      hif.ID_EX_RegWrite = $urandom_range(1, 0);
      hif.ID_EX_Rd       = 5'($urandom_range(3, 0));
      hif.EX_MEM_MemRead = $urandom_range(1, 0);
      hif.EX_MEM_Rd      = 5'($urandom_range(3, 0));
      hif.IF_ID_Rs       = 5'($urandom_range(3, 0));
      hif.IF_ID_Rt       = 5'($urandom_range(3, 0));
      hif.IF_ID_UseRt    = $urandom_range(1, 0);
      hif.ID_Branch      = $urandom_range(1, 0);
      hif.ID_BranchTaken = $urandom_range(1, 0);
      hif.ID_MdStart     = ($urandom_range(3, 0) == 0);
      hif.ID_MfHiLo      = ($urandom_range(3, 0) == 0);
      rst                = ($urandom_range(39, 0) == 0);
      tick();
    end
    rst = 0;
    clr();
    tick();
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
Stall/flush controller for the 5-stage pipeline, complementing operand forwarding. Forwarding cannot cover load-use hazards, ID-stage branch compares, or in-flight multi-cycle mult/div results; this block covers those cases. It detects these hazards and drives PC/IF_ID write enables, ID_EX bubble insertion and IF_ID flush. It tracks mult/div occupancy with an internal FSM and down-counter.

Parameters:
MD_LATENCY, 32, cycles the HI/LO unit stays busy after a mult/div is accepted (legal range 1..255)
CNT_W, 8, width of the internal busy counter (must hold MD_LATENCY)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
ID_EX_MemRead  input  1  instruction in EX is a load
ID_EX_RegWrite  input  1  instruction in EX writes a register
ID_EX_Rd  input  5  EX destination register (post RegDst mux)
EX_MEM_MemRead  input  1  instruction in MEM is a load
EX_MEM_Rd  input  5  MEM destination register
IF_ID_Rs  input  5  ID source register rs
IF_ID_Rt  input  5  ID source register rt
IF_ID_UseRt  input  1  ID instruction actually reads rt
ID_Branch  input  1  ID holds a branch resolved in ID
ID_BranchTaken  input  1  ID branch compare result
ID_MdStart  input  1  ID holds mult/div
ID_MfHiLo  input  1  ID holds mfhi/mflo
PCWrite  output  1  PC update enable
IF_ID_Write  output  1  IF_ID register write enable
ID_EX_Bubble  output  1  zero control fields entering ID_EX
IF_ID_Flush  output  1  squash instruction entering IF_ID
MdBusy  output  1  mult/div unit occupied
StallCount  output  32  total stall cycles (see Optional Feature)

Behaviour:
- match(r) = r!=0 && (r==IF_ID_Rs || (IF_ID_UseRt && r==IF_ID_Rt)).
- load_use = ID_EX_MemRead && match(ID_EX_Rd).
- br_haz = ID_Branch && ((ID_EX_RegWrite && match(ID_EX_Rd)) || (EX_MEM_MemRead && match(EX_MEM_Rd))).
- md_haz = MdBusy && (ID_MfHiLo || ID_MdStart).
- stall = load_use || br_haz || md_haz. All outputs are combinational from registered state plus inputs.
- stall=1: PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1, IF_ID_Flush=0. Stall overrides taken branch; the branch re-evaluates next cycle.
- stall=0: PCWrite=1, IF_ID_Write=1, ID_EX_Bubble=0, IF_ID_Flush = ID_Branch && ID_BranchTaken.
- FSM states: RUN, MD_BUSY.
- RUN: if ID_MdStart && !stall, load cnt=MD_LATENCY and go to MD_BUSY.
- MD_BUSY: if cnt==1, go to RUN and set cnt=0; otherwise cnt decrements by 1.
- MdBusy = (state==MD_BUSY). It is high for exactly MD_LATENCY cycles, starting the cycle after acceptance.
- Back-to-back mult/div while busy: md_haz stalls it until RUN, then it is accepted normally. No overlap.
- MD_LATENCY=1: busy exactly one cycle.
- Reset, including mid-MD_BUSY: state=RUN, cnt=0, MdBusy=0, StallCount=0.
- Outputs while rst=1: PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1, IF_ID_Flush=1.
- First cycle after rst deasserts: normal evaluation.

Optional Feature:
HAZARD_STALL_COUNTER_EN. When defined, StallCount increments by 1 on every non-reset cycle with stall=1. It saturates at 32'hFFFFFFFF and clears on rst. When undefined, StallCount is tied to 0 and no counter logic is generated.

Test Plan:
- Load-use: ID_EX_MemRead=1, ID_EX_Rd=8, IF_ID_Rs=8 -> one cycle PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1. Repeat with ID_EX_Rd=0 -> no stall.
- Rt gating: ID_EX_Rd=9=IF_ID_Rt, load in EX, IF_ID_UseRt=0 -> no stall; with UseRt=1 -> stall.
- Branch hazard: ID_Branch=1, ID_BranchTaken=1, EX_MEM_MemRead=1, EX_MEM_Rd=IF_ID_Rs=5 -> stall with IF_ID_Flush=0. Next cycle, hazard removed -> IF_ID_Flush=1, PCWrite=1.
- Mult/div: MD_LATENCY=4, ID_MdStart=1 accepted at cycle t -> MdBusy=1 in cycles t+1..t+4, 0 at t+5. ID_MfHiLo=1 at t+2 -> stalls t+2..t+4, proceeds at t+5.
- Reset mid-busy: rst=1 at t+2 -> MdBusy=0 next cycle; reset output values held during rst; StallCount=0.
- With HAZARD_STALL_COUNTER_EN: 3 load-use stalls plus 3 md stalls -> StallCount=6. Without the macro -> StallCount=0 throughout.
